// File: rtl/azadi_wb_pkg.sv
// Shared Wishbone host definitions: FSM state encoding, default bus widths
// and the registered request bundle that drives the wbm_* outputs.
package azadi_wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = WB_DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_host_state_e;

    // Bundle is sized by the package widths; AW/DW overrides on the host must match.
    typedef struct packed {
        logic              cyc;
        logic              stb;
        logic              we;
        logic [WB_AW-1:0]  adr;
        logic [WB_DW-1:0]  dat;
        logic [WB_SW-1:0]  sel;
    } wb_req_t;

endpackage

// File: rtl/wb_host_master.sv
// Wishbone B4 classic initiator: one valid/ready request becomes one bus cycle,
// and every accepted request yields exactly one response (ack or timeout abort).
module wb_host_master
    import azadi_wb_pkg::*;
#(
    parameter int AW             = WB_AW,
    parameter int DW             = WB_DW,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int SW            = DW / 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    input  logic [SW-1:0] req_sel_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic          wbm_we_o,
    output logic [AW-1:0] wbm_adr_o,
    output logic [DW-1:0] wbm_dat_o,
    output logic [SW-1:0] wbm_sel_o,
    input  logic [DW-1:0] wbm_dat_i,
    input  logic          wbm_ack_i
);

    localparam int            TW         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    wb_host_state_e state_q, state_d;
    wb_req_t        bus_q, bus_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_err_q, rsp_err_d;
    logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [TW-1:0]  timer_q, timer_d;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            bus_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        timer_d     = timer_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    bus_d.cyc = 1'b1;
                    bus_d.stb = 1'b1;
                    bus_d.we  = req_we_i;
                    bus_d.adr = req_addr_i;
                    bus_d.dat = req_wdata_i;
                    bus_d.sel = req_sel_i;
                    timer_d   = '0;
                    state_d   = BUS;
                end
            end
            BUS: begin
                timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
                // Ack has priority over a timeout landing in the same cycle.
                if (wbm_ack_i) begin
                    bus_d.cyc   = 1'b0;
                    bus_d.stb   = 1'b0;
                    rsp_rdata_d = bus_q.we ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
                    bus_d.cyc   = 1'b0;
                    bus_d.stb   = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o = (state_q == IDLE) && wb_rst_ni;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign wbm_cyc_o   = bus_q.cyc;
    assign wbm_stb_o   = bus_q.stb;
    assign wbm_we_o    = bus_q.we;
    assign wbm_adr_o   = bus_q.adr;
    assign wbm_dat_o   = bus_q.dat;
    assign wbm_sel_o   = bus_q.sel;

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master: directed cases plus random
// transactions scored against a transaction-level expectation model.
module tb_wb_host_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          wbm_cyc;
    logic          wbm_stb;
    logic          wbm_we;
    logic [AW-1:0] wbm_adr;
    logic [DW-1:0] wbm_dat_o;
    logic [SW-1:0] wbm_sel;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack;

    int total = 0;
    int bad   = 0;

    wb_host_master #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_we_i   (req_we),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .req_sel_i  (req_sel),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .wbm_cyc_o  (wbm_cyc),
        .wbm_stb_o  (wbm_stb),
        .wbm_we_o   (wbm_we),
        .wbm_adr_o  (wbm_adr),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_sel_o  (wbm_sel),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one request at the current falling edge and scrambles the
    // request fields once it has been taken.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] sel);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_sel   = sel;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom());
        req_addr  = $urandom();
        req_wdata = $urandom();
        req_sel   = 4'($urandom());
    endtask

    // ack_cycle: stb cycle (1-based) on which the responder acks, 0 = never.
    // late_ack_at: RESP-wait cycle carrying a stray ack; at/after rsp_delay it lands in IDLE.
    task automatic runTransaction(input string name, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] sel,
                                  input logic [31:0] rdata, input int ack_cycle,
                                  input int rsp_delay, input int late_ack_at);
        int          stb_cycles;
        int          exp_stb;
        logic        exp_err;
        logic [31:0] exp_rdata;

        if (ack_cycle >= 1 && ack_cycle <= TO) begin
            exp_err   = 1'b0;
            exp_rdata = we ? 32'h0 : rdata;
            exp_stb   = ack_cycle;
        end else begin
            exp_err   = 1'b1;
            exp_rdata = 32'h0;
            exp_stb   = TO;
        end

        checkOutput({name, ".ready_idle"}, 64'(req_ready), 64'(1));
        applyStimulus(we, addr, wdata, sel);

        stb_cycles = 0;
        for (int n = 1; n <= TO + 20; n++) begin
            if (!wbm_stb) break;
            stb_cycles++;
            checkOutput({name, ".bus_ctl"}, 64'({wbm_cyc, wbm_we, wbm_sel, wbm_adr}),
                        64'({1'b1, we, sel, addr}));
            checkOutput({name, ".bus_dat"}, 64'(wbm_dat_o), 64'(wdata));
            checkOutput({name, ".busy"}, 64'({req_ready, rsp_valid}), 64'(0));
            wbm_ack   = (n == ack_cycle);
            wbm_dat_i = (n == ack_cycle) ? rdata : $urandom();
            @(negedge clk);
            wbm_ack   = 1'b0;
        end
        checkOutput({name, ".stb_cycles"}, 64'(stb_cycles), 64'(exp_stb));
        checkOutput({name, ".cyc_drop"}, 64'({wbm_cyc, wbm_stb}), 64'(0));

        for (int k = 0; k < rsp_delay; k++) begin
            checkOutput({name, ".rsp_hold"}, 64'({rsp_valid, rsp_err, rsp_rdata}),
                        64'({1'b1, exp_err, exp_rdata}));
            checkOutput({name, ".ready_resp"}, 64'({req_ready, wbm_cyc}), 64'(0));
            wbm_ack   = (k == late_ack_at);
            wbm_dat_i = $urandom();
            @(negedge clk);
            wbm_ack   = 1'b0;
        end
        checkOutput({name, ".rsp"}, 64'({rsp_valid, rsp_err, rsp_rdata}),
                    64'({1'b1, exp_err, exp_rdata}));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({name, ".after_hs"}, 64'({req_ready, rsp_valid, wbm_cyc}), 64'(3'b100));

        if (late_ack_at >= rsp_delay) begin
            wbm_ack = 1'b1;
            @(negedge clk);
            wbm_ack = 1'b0;
            checkOutput({name, ".idle_ack"}, 64'({req_ready, rsp_valid, wbm_cyc, wbm_stb}),
                        64'(4'b1000));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;
        wbm_dat_i = '0;
        wbm_ack   = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset.ctl", 64'({req_ready, rsp_valid, rsp_err, wbm_cyc, wbm_stb, wbm_we, wbm_sel}),
                    64'(0));
        checkOutput("reset.adr", 64'(wbm_adr), 64'(0));
        checkOutput("reset.dat", 64'(wbm_dat_o), 64'(0));
        checkOutput("reset.rdata", 64'(rsp_rdata), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        runTransaction("write", 1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 32'hDEAD_BEEF, 1, 0, -1);
        runTransaction("read_wait", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'h1234_5678, 4, 0, -1);
        runTransaction("timeout", 1'b0, 32'h3000_0020, 32'h0, 4'h3, 32'h0, 0, 5, 2);
        runTransaction("timeout_idle_ack", 1'b1, 32'h3000_0024, 32'h55AA_00FF, 4'h1, 32'h0, 0, 0, 0);
        runTransaction("backpressure", 1'b0, 32'h3000_0030, 32'h0, 4'hC, 32'hCAFE_F00D, 2, 5, -1);

        // Reset pulse while the bus cycle is in flight.
        checkOutput("rst_bus.ready", 64'(req_ready), 64'(1));
        applyStimulus(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        checkOutput("rst_bus.stb", 64'({wbm_cyc, wbm_stb}), 64'(2'b11));
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_bus.drop", 64'({wbm_cyc, wbm_stb, rsp_valid, req_ready}), 64'(0));
        rst_n = 1'b1;
        #1;
        checkOutput("rst_bus.ready_back", 64'(req_ready), 64'(1));
        @(negedge clk);
        checkOutput("rst_bus.no_rsp", 64'({rsp_valid, wbm_cyc}), 64'(0));
        runTransaction("read_after_rst", 1'b0, 32'h3000_0044, 32'h0, 4'hF, 32'h0BAD_F00D, 1, 1, -1);

        runTransaction("ack_at_limit", 1'b0, 32'h3000_0050, 32'h0, 4'hF, 32'h7777_1111, TO, 0, -1);
        runTransaction("ack_past_limit", 1'b0, 32'h3000_0054, 32'h0, 4'hF, 32'h7777_2222, TO + 1, 1, -1);

        for (int t = 0; t < 24; t++) begin
            runTransaction("random", 1'($urandom()), $urandom(), $urandom(), 4'($urandom()), $urandom(),
                           int'($urandom_range(0, TO + 2)), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
